// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/full_subtractor_1.sv
// One-bit full subtractor: diff = a - b - bin, with borrow-out.
module full_subtractor_1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock; result a - b - bin.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    sub_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             br_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q;
`endif

    logic d_s;
    logic bo_s;
    logic last_s;

    full_subtractor_1 u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .diff (d_s),
        .bout (bo_s)
    );

    assign last_s = (cnt_q == CW'(WIDTH - 1));

    // Control FSM and serial datapath; operands shift right so bit 0 is always the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    diff_q <= {d_s, diff_q[WIDTH-1:1]};
                    a_q    <= {1'b0, a_q[WIDTH-1:1]};
                    b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    br_q   <= bo_s;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_s) begin
                        bout_q  <= bo_s;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
                        ovf_q   <= br_q ^ bo_s;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus hand-written corner sequences.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = SUB_DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    vec_t ops[4];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: done with empty scoreboard, got diff 0x%0h expected no result", name, diff);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_diff"}, 32'(diff), 32'(e.diff));
            chk({name, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            chk({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    // Drive operands with start; returns just after the accepting edge.
    task automatic start_op(input vec_t v);
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        start = 1'b1;
        sb_q.push_back('{v.diff, v.bout, v.ovf});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic wait_done(input string name, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                sb_check(name);
                return;
            end
            if (busy) busy_cycles++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, got no done in 40 cycles, expected done within %0d", name, W + 1);
    endtask

    initial begin
        int cyc;
        int bcyc;
        int dc0;
        bit found;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[8] = '{8'h3C, 8'hC3, 1'b1, 8'h78, 1'b1, 1'b0};
        vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i]);
            wait_done($sformatf("vec%0d", i), cyc, bcyc);
            chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(W + 1));
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'(W));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d_hold", i), 32'(diff), 32'(vecs[i].diff));
        end

        // Start re-pulsed with new operands during RUN must be ignored.
        start_op(vecs[0]);
        #1;
        dc0 = done_cnt;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a     = 8'hAA;
        b     = 8'h11;
        bin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore", cyc, bcyc);
        chk("ignore_latency", 32'(cyc), 32'(W - 2));
        repeat (12) @(negedge clk);
        #1;
        chk("ignore_single_done", 32'(done_cnt), 32'(dc0 + 1));
        chk("ignore_idle_busy", 32'(busy), 32'd0);

        // Reset mid-RUN aborts without done; start accepted on the first edge after release.
        start_op('{8'hC3, 8'h21, 1'b0, 8'hA2, 1'b0, 1'b0});
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        sb_q.delete();
        dc0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_op(vecs[7]);
        wait_done("postrst", cyc, bcyc);
        chk("postrst_latency", 32'(cyc), 32'(W + 1));
        #1;
        chk("postrst_done_count", 32'(done_cnt), 32'(dc0 + 1));
        @(negedge clk);

        // Start held high: back-to-back results, busy low only in DONE.
        ops[0] = vecs[0];
        ops[1] = vecs[1];
        ops[2] = vecs[3];
        ops[3] = vecs[2];
        a     = ops[0].a;
        b     = ops[0].b;
        bin   = ops[0].bin;
        start = 1'b1;
        sb_q.push_back('{ops[0].diff, ops[0].bout, ops[0].ovf});
        for (int k = 0; k < 4; k++) begin
            cyc   = 0;
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                cyc++;
                if (done) found = 1'b1;
                else chk($sformatf("b2b%0d_busy", k), 32'(busy), 32'd1);
            end
            if (!found) begin
                n_tests++;
                n_fail++;
                $display("FAIL b2b%0d: timeout, got no done in 20 cycles, expected %0d", k, W + 1);
                break;
            end
            chk($sformatf("b2b%0d_busy_in_done", k), 32'(busy), 32'd0);
            chk($sformatf("b2b%0d_period", k), 32'(cyc), 32'(W + 1));
            sb_check($sformatf("b2b%0d", k));
            if (k < 3) begin
                a   = ops[k+1].a;
                b   = ops[k+1].b;
                bin = ops[k+1].bin;
                sb_q.push_back('{ops[k+1].diff, ops[k+1].bout, ops[k+1].ovf});
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_end_busy", 32'(busy), 32'd0);
        chk("b2b_end_done", 32'(done), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
